// File: rtl/ysyx_23060077_riscv_lsu_axi_pkg.sv
// Shared constants for the LSU: funct3 encodings, FSM states, AXI response codes.
// Optional misalign trap is selected by YSYX_23060077_LSU_MISALIGN_CHECK_EN.
package ysyx_23060077_riscv_lsu_axi_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } lsu_state_e;

    // Width of the byte offset within one bus beat
    function automatic int unsigned lsu_offset_w(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ysyx_23060077_riscv_lsu_axi_if.sv
// Request/response and AXI4-Lite master signals of the LSU.
// master = LSU side, slave = execute stage plus memory system.
interface ysyx_23060077_riscv_lsu_axi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_is_store;
    logic [2:0]              req_funct3;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_err;
    logic                    resp_misalign;

    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err, resp_misalign,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err, resp_misalign,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ysyx_23060077_riscv_lsu_lane.sv
// Byte-lane logic of the LSU: store shift/strobe, load shift/extend,
// funct3 legality and (with YSYX_23060077_LSU_MISALIGN_CHECK_EN) misalign check.
module ysyx_23060077_riscv_lsu_lane
    import ysyx_23060077_riscv_lsu_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                             i_funct3,
    input  logic                                   i_is_store,
    input  logic [lsu_offset_w(DATA_WIDTH)-1:0]    i_offset,
    input  logic [DATA_WIDTH-1:0]                  i_wdata,
    output logic [DATA_WIDTH-1:0]                  o_st_data,
    output logic [DATA_WIDTH/8-1:0]                o_st_strb,
    output logic                                   o_illegal,
    output logic                                   o_misalign,
    input  logic [2:0]                             i_ld_funct3,
    input  logic [lsu_offset_w(DATA_WIDTH)-1:0]    i_ld_offset,
    input  logic [DATA_WIDTH-1:0]                  i_rdata,
    output logic [DATA_WIDTH-1:0]                  o_ld_data
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int OFFSET_W = lsu_offset_w(DATA_WIDTH);

    logic [NB-1:0]         w_ones;
    logic [DATA_WIDTH-1:0] w_sh;

    // Store side: lane shift, strobe and request legality
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_ones = NB'(8'h01);
            2'b01:   w_ones = NB'(8'h03);
            2'b10:   w_ones = NB'(8'h0F);
            default: w_ones = NB'(8'hFF);
        endcase
        o_st_data = i_wdata << {i_offset, 3'b000};
        o_st_strb = w_ones << i_offset;
        o_illegal = (i_funct3 == F3_BAD) || (i_is_store && i_funct3[2]) ||
                    ((DATA_WIDTH == 32) && ((i_funct3 == F3_LD) || (i_funct3 == F3_LWU)));
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        o_misalign = |(i_offset & OFFSET_W'((4'd1 << i_funct3[1:0]) - 4'd1));
`else
        o_misalign = 1'b0;
`endif
    end

    // Load side: shift addressed bytes down, then extend per funct3
    always_comb begin
        w_sh = i_rdata >> {i_ld_offset, 3'b000};
        case (i_ld_funct3)
            F3_LB:   o_ld_data = DATA_WIDTH'($signed(w_sh[7:0]));
            F3_LH:   o_ld_data = DATA_WIDTH'($signed(w_sh[15:0]));
            F3_LW:   o_ld_data = DATA_WIDTH'($signed(w_sh[31:0]));
            F3_LD:   o_ld_data = w_sh;
            F3_LBU:  o_ld_data = DATA_WIDTH'(w_sh[7:0]);
            F3_LHU:  o_ld_data = DATA_WIDTH'(w_sh[15:0]);
            F3_LWU:  o_ld_data = DATA_WIDTH'(w_sh[31:0]);
            default: o_ld_data = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_23060077_riscv_lsu_axi.sv
// LSU top: request capture, AXI4-Lite master FSM and single-cycle response.
// Optional misalign trap: define YSYX_23060077_LSU_MISALIGN_CHECK_EN.
module ysyx_23060077_riscv_lsu_axi
    import ysyx_23060077_riscv_lsu_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_23060077_riscv_lsu_axi_if.master bus
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int OFFSET_W = lsu_offset_w(DATA_WIDTH);

    lsu_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic                  r_aw_done, r_w_done;
    logic                  r_resp_valid, r_resp_err, r_resp_misalign;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic [DATA_WIDTH-1:0] w_st_data, w_ld_data;
    logic [NB-1:0]         w_st_strb;
    logic                  w_illegal, w_misalign, w_aw_fin, w_w_fin;

    ysyx_23060077_riscv_lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .i_funct3    (bus.req_funct3),
        .i_is_store  (bus.req_is_store),
        .i_offset    (bus.req_addr[OFFSET_W-1:0]),
        .i_wdata     (bus.req_wdata),
        .o_st_data   (w_st_data),
        .o_st_strb   (w_st_strb),
        .o_illegal   (w_illegal),
        .o_misalign  (w_misalign),
        .i_ld_funct3 (r_funct3),
        .i_ld_offset (r_addr[OFFSET_W-1:0]),
        .i_rdata     (bus.rdata),
        .o_ld_data   (w_ld_data)
    );

    assign w_aw_fin = r_aw_done || (r_awvalid && bus.awready);
    assign w_w_fin  = r_w_done  || (r_wvalid  && bus.wready);

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_err      = r_resp_err;
    assign bus.resp_misalign = r_resp_misalign;
    assign bus.arvalid       = r_arvalid;
    assign bus.araddr        = r_addr;
    assign bus.rready        = r_rready;
    assign bus.awvalid       = r_awvalid;
    assign bus.awaddr        = r_addr;
    assign bus.wvalid        = r_wvalid;
    assign bus.wdata         = r_wdata;
    assign bus.wstrb         = r_wstrb;
    assign bus.bready        = r_bready;

    // Request/bus FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_funct3        <= '0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_arvalid       <= 1'b0;
            r_rready        <= 1'b0;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_bready        <= 1'b0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_err      <= 1'b0;
            r_resp_misalign <= 1'b0;
            r_resp_data     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    // store data is captured already lane-shifted
                    r_addr   <= bus.req_addr;
                    r_funct3 <= bus.req_funct3;
                    r_wdata  <= w_st_data;
                    r_wstrb  <= w_st_strb;
                    if (w_illegal || w_misalign) begin
                        r_state         <= S_DONE;
                        r_resp_valid    <= 1'b1;
                        r_resp_err      <= w_illegal;
                        r_resp_misalign <= !w_illegal;
                        r_resp_data     <= '0;
                    end else if (bus.req_is_store) begin
                        r_state   <= S_WR_REQ;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_state   <= S_RD_ADDR;
                        r_arvalid <= 1'b1;
                    end
                end
                S_RD_ADDR: if (bus.arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= S_RD_DATA;
                end
                S_RD_DATA: if (bus.rvalid) begin
                    r_rready     <= 1'b0;
                    r_state      <= S_DONE;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= (bus.rresp != AXI_RESP_OKAY);
                    r_resp_data  <= (bus.rresp == AXI_RESP_OKAY) ? w_ld_data : '0;
                end
                S_WR_REQ: begin
                    // AW and W retire independently, in any order
                    if (r_awvalid && bus.awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && bus.wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: if (bus.bvalid) begin
                    r_bready     <= 1'b0;
                    r_state      <= S_DONE;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= (bus.bresp != AXI_RESP_OKAY);
                    r_resp_data  <= '0;
                end
                S_DONE: begin
                    r_resp_err      <= 1'b0;
                    r_resp_misalign <= 1'b0;
                    r_resp_data     <= '0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060077_riscv_lsu_axi.md
Name: ysyx_23060077_riscv_lsu_axi

Overview:
Parametrised successor load/store unit for the riscv core. It accepts one load or store per request from the execute stage and generates byte-lane-aligned data and strobes. It drives an AXI4-Lite master directly, with independent AW/W channels and B/R responses. It returns sign/zero-extended load data and error/misalign status through a single-cycle response pulse.

Parameters:
DATA_WIDTH, 32, bus and register data width; legal values 32 or 64.
ADDR_WIDTH, 32, address width of req_addr and AXI addresses.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  execute stage presents an access
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (size/sign)
req_addr  in  ADDR_WIDTH  effective address (src1+imm computed upstream)
req_wdata  in  DATA_WIDTH  store source (src2), LSB-justified
resp_valid  out  1  one-cycle pulse, no backpressure
resp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  bus error or illegal funct3
resp_misalign  out  1  misaligned access (optional feature)
awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH  AXI write address
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  AXI write data
bvalid/bready/bresp  in/out/in  1/1/2  AXI write response
arvalid/arready/araddr  out/in/out  1/1/ADDR_WIDTH  AXI read address
rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  AXI read data

Behaviour:
- Reset: FSM=IDLE; all AXI valid/ready outputs 0; resp_valid/resp_err/resp_misalign 0; resp_data 0; captured request regs 0. Reset mid-transaction drops all outputs immediately and produces no response. The bench must not reuse the in-flight slave transaction.
- Accept: addr, funct3, is_store and wdata are registered on the accept edge; req_* may change afterwards.
- Sizes: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
  - Stores use 000..011 only.
  - When DATA_WIDTH=32: 011, 110, 111 are illegal.
  - Always illegal: 111; store with funct3 >= 100.
- Illegal funct3: no bus access; resp_valid next cycle with resp_err=1.
- Lanes: offset = addr[log2(DATA_WIDTH/8)-1:0].
  - wdata = req_wdata << 8*offset.
  - wstrb = ((1<<size_bytes)-1) << offset, truncated to DATA_WIDTH/8 bits.
  - araddr/awaddr carry the unmodified address.
- Load data: rdata >> 8*offset, then sign- or zero-extend per funct3 to DATA_WIDTH.
- States:
  - IDLE -> RD_ADDR on load accept.
  - IDLE -> WR_REQ on store accept.
  - IDLE -> DONE on illegal or misaligned access.
  - RD_ADDR: arvalid=1 until arready; then RD_DATA.
  - RD_DATA: rready=1 until rvalid; latch data/rresp; then DONE.
  - WR_REQ: awvalid and wvalid both asserted. Each is dropped independently after its own handshake (aw_done/w_done flags). Both may complete in the same cycle or in any order. Go to WR_RESP once both are done.
  - WR_RESP: bready=1 until bvalid; latch bresp; then DONE.
  - DONE: resp_valid=1 for one cycle; return to IDLE.
- Valid stays asserted until handshake, and the address/data held on it are stable (AXI rule).
- Latency with a zero-wait slave, accept at edge N:
  - load: arvalid in cycle N+1, rready in N+2, resp_valid in N+3.
  - store: aw/wvalid in N+1, bready in N+2, resp_valid in N+3.
  - illegal/misaligned: resp_valid in N+1.
- resp_err=1 when rresp/bresp != 2'b00; resp_data=0 in that case.
- req_ready=0 from accept until the cycle after the resp_valid pulse (IDLE re-entered).

Optional Feature:
Macro: YSYX_23060077_LSU_MISALIGN_CHECK_EN.
- Defined: an access with offset not a multiple of the access size issues no bus access; resp_valid next cycle with resp_misalign=1, resp_err=0, resp_data=0.
- Undefined: no check. The access is issued as-is; strobe/data bits shifted past the bus width are discarded. resp_misalign is tied 0.

Decomposition:
- Package constants: funct3 encodings (LB..LWU, SB..SD), FSM state encoding (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE), AXI_RESP_OKAY=2'b00, derived OFFSET_W=log2(DATA_WIDTH/8).
- One combinational sub-module, ysyx_23060077_riscv_lsu_lane. It holds the store shift/strobe generation, load shift/extend, legality check and misalign check. The top holds the FSM and AXI registers.

Test Plan:
- DATA_WIDTH=32, load lb addr 0x8000_0003, zero-wait slave, rdata 0x80FF_0000 -> araddr 0x8000_0003, resp_valid at N+3, resp_data 0xFFFF_FF80.
- Store sh addr 0x102, wdata 0x1234_ABCD, awready delayed 3 cycles, wready immediate -> wdata 0xABCD_0000, wstrb 4'b1100, wvalid drops after 1 cycle, awvalid holds until its handshake, single resp_valid, resp_err=0.
- DATA_WIDTH=64, ld addr 0x8, rdata 0xDEAD_BEEF_0123_4567, rresp=2'b10 -> resp_err=1, resp_data=0.
- DATA_WIDTH=32, funct3 011 load -> no arvalid, resp_valid at N+1 with resp_err=1.
- With macro, lw addr 0x2 -> no bus access, resp_misalign=1 at N+1. Without macro -> arvalid issued and resp_misalign=0.
- Assert rst_n low while in RD_DATA -> arvalid/rready/resp_valid 0 immediately. After release, req_ready=1 and a new lbu completes normally.
